serial_subtractor: RTL and testbench

// Bit-serial subtractor: the subtract counterpart of the team's ripple full adder.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor. It computes diff = a - b - bin one bit per clock,
//   LSB first, using a single full-subtractor cell and a registered borrow.
//   Operands are taken on a start handshake, and the result is held on a
//   done handshake.
//
//   Handshake rule (both sides): a transfer happens on a rising clk edge
//   where valid and ready are both 1. Valid never depends on ready in the
//   same cycle.
//     start_valid/start_ready : the producer offers a_in/b_in/bin. Ready is
//                               high only in IDLE.
//     done_valid/done_ready   : the consumer takes diff/bout. Valid is high
//                               only in DONE.
//
// Ports
//   clk, rst_n        rising-edge clock, async active-low reset
//   start_valid/ready operand handshake
//   a_in, b_in, bin   minuend, subtrahend, borrow-in (sampled at accept only)
//   diff, bout        result (a-b-bin) mod 2^WIDTH, and borrow-out
//   done_valid/ready  result handshake
//   busy              high in SHIFT or DONE
//   dbg_state         current FSM state (0 IDLE, 1 SHIFT, 2 DONE)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  state_e          state_q;
  logic [WIDTH-1:0] a_q, b_q, diff_q;
  logic            borrow_q, bout_q;
  logic [CW-1:0]   cnt_q;

  logic            a0, b0, d_bit, borrow_d;
  logic [WIDTH-1:0] diff_d;

  // Full-subtractor cell on the current LSBs, plus the next diff register
  // value with the new bit entering at the MSB.
  always_comb begin
    a0       = a_q[0];
    b0       = b_q[0];
    d_bit    = a0 ^ b0 ^ borrow_q;
    borrow_d = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
    diff_d   = diff_q >> 1;
    diff_d[WIDTH-1] = d_bit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            a_q      <= a_in;
            b_q      <= b_in;
            borrow_q <= bin;
            cnt_q    <= '0;
            state_q  <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          diff_q   <= diff_d;
          borrow_q <= borrow_d;
          cnt_q    <= cnt_q + CW'(1);
          // The last bit position produces the final borrow-out.
          if (cnt_q == LAST) begin
            bout_q  <= borrow_d;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          // diff/bout are left untouched on leaving; only done_valid drops.
          if (done_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready = (state_q == S_IDLE);
  assign done_valid  = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign diff        = diff_q;
  assign bout        = bout_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- WIDTH=8 instance ----------------
  logic       sv8 = 0, dr8 = 0, bin8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic       sr8, bout8, dv8, busy8;
  logic [7:0] diff8;
  logic [1:0] st8;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv8), .start_ready(sr8),
    .a_in(a8), .b_in(b8), .bin(bin8), .diff(diff8), .bout(bout8),
    .done_valid(dv8), .done_ready(dr8), .busy(busy8), .dbg_state(st8)
  );

  // ---------------- WIDTH=4 instance ----------------
  logic       sv4 = 0, dr4 = 0, bin4 = 0;
  logic [3:0] a4 = 0, b4 = 0;
  logic       sr4, bout4, dv4, busy4;
  logic [3:0] diff4;
  logic [1:0] st4;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv4), .start_ready(sr4),
    .a_in(a4), .b_in(b4), .bin(bin4), .diff(diff4), .bout(bout4),
    .done_valid(dv4), .done_ready(dr4), .busy(busy4), .dbg_state(st4)
  );

  // ---------------- WIDTH=1 instance ----------------
  logic sv1 = 0, dr1 = 0, bin1 = 0;
  logic a1 = 0, b1 = 0;
  logic sr1, bout1, dv1, busy1;
  logic diff1;
  logic [1:0] st1;

  serial_subtractor #(.WIDTH(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_valid(sv1), .start_ready(sr1),
    .a_in(a1), .b_in(b1), .bin(bin1), .diff(diff1), .bout(bout1),
    .done_valid(dv1), .done_ready(dr1), .busy(busy1), .dbg_state(st1)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {bout, diff} expected for each accepted WIDTH=8 op
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned subtraction one bit wider than the operands; the top
  // bit is the borrow-out.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'd0, bi};
  endfunction

  function automatic logic [4:0] model4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {4'd0, bi};
  endfunction

  // ---------------- driver tasks ----------------
  // One WIDTH=8 op. noisy: scramble inputs and hold start_valid during SHIFT
  // and DONE. hold: cycles to hold done_ready low in DONE before release.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                      input bit noisy, input int hold);
    logic [8:0] e;
    int n;
    @(negedge clk);
    chk("idle_start_ready", sr8, 1);
    a8 = a; b8 = b; bin8 = bi; sv8 = 1;
    exp_q.push_back(model8(a, b, bi));
    @(posedge clk);
    @(negedge clk);
    if (!noisy) sv8 = 0;
    chk("busy_after_accept", busy8, 1);
    n = 0;
    while (!dv8 && n < 40) begin
      if (noisy) begin
        a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
      end
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("latency", n, 8);
    e = exp_q.pop_front();
    chk("diff", diff8, e[7:0]);
    chk("bout", bout8, e[8]);
    chk("done_start_ready", sr8, 0);
    for (int i = 0; i < hold; i++) begin
      sv8 = 1'($urandom_range(0, 1));
      a8 = 8'($urandom); b8 = 8'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", dv8, 1);
      chk("hold_diff", diff8, e[7:0]);
      chk("hold_bout", bout8, e[8]);
      chk("hold_start_ready", sr8, 0);
    end
    sv8 = 0; dr8 = 1;
    @(posedge clk);
    @(negedge clk);
    dr8 = 0;
    chk("release_valid", dv8, 0);
    chk("release_start_ready", sr8, 1);
    chk("release_diff_kept", diff8, e[7:0]);
    chk("release_bout_kept", bout8, e[8]);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    logic [4:0] e;
    int n;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bi; sv4 = 1;
    e = model4(a, b, bi);
    @(posedge clk);
    @(negedge clk);
    sv4 = 0;
    n = 0;
    while (!dv4 && n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("w4_latency", n, 4);
    chk("w4_diff", diff4, e[3:0]);
    chk("w4_bout", bout4, e[4]);
    dr4 = 1;
    @(posedge clk);
    @(negedge clk);
    dr4 = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    #1;
    chk("rst_start_ready", sr8, 1);
    chk("rst_done_valid", dv8, 0);
    chk("rst_busy", busy8, 0);
    chk("rst_diff", diff8, 0);
    chk("rst_bout", bout8, 0);
    chk("rst_state", st8, 0);
    // Handshakes are ignored in reset.
    sv8 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ignores_start", busy8, 0);
    sv8 = 0;
    rst_n = 1;

    // Directed cases.
    run8(8'h5A, 8'h3C, 1'b0, 0, 0);
    run8(8'h00, 8'h01, 1'b0, 0, 0);
    run8(8'h10, 8'h10, 1'b1, 0, 0);
    run8(8'hFF, 8'h00, 1'b1, 0, 0);
    // Backpressure with start pulses in DONE.
    run8(8'hC3, 8'h7E, 1'b1, 0, 5);
    // Inputs change every cycle after accept; back-to-back ops.
    run8(8'h81, 8'h92, 1'b0, 1, 2);
    run8(8'h33, 8'h33, 1'b0, 1, 0);

    // Reset in the middle of SHIFT.
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; bin8 = 0; sv8 = 1;
    @(posedge clk);
    @(negedge clk);
    sv8 = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("midrst_done_valid", dv8, 0);
    chk("midrst_diff", diff8, 0);
    chk("midrst_bout", bout8, 0);
    chk("midrst_start_ready", sr8, 1);
    @(negedge clk);
    rst_n = 1;
    run8(8'h80, 8'h01, 1'b0, 0, 0);

    // Random ops.
    for (int i = 0; i < 60; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)));

    // WIDTH=4 exhaustive.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(4'(a), 4'(b), 1'(c));

    // WIDTH=1 smoke: 0 - 1 - 0.
    @(negedge clk);
    a1 = 0; b1 = 1; bin1 = 0; sv1 = 1;
    @(posedge clk);
    @(negedge clk);
    sv1 = 0;
    n = 0;
    while (!dv1 && n < 10) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk("w1_latency", n, 1);
    chk("w1_diff", diff1, 1);
    chk("w1_bout", bout1, 1);
    dr1 = 1;
    @(posedge clk);
    @(negedge clk);
    dr1 = 0;
    chk("w1_release", sr1, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
